word_pipe_latch: RTL

//   Parametrised, elastic successor to the plain word latch / write-enabled word latch.
//   - DEPTH chained stages carry a WIDTH-bit word with valid/ready flow control.
//   - Each stage is a 2-entry skid buffer, so backpressure never loses or duplicates a word.
//   - Synchronous flush empties the whole chain (branch/jump squash).
//   - Sits between CPU datapath stages, e.g. fetch->decode (instruction word), replacing per-register wren muxing.

---
 rtl/word_pipe_latch_pkg.sv | 16 +
 rtl/word_pipe_latch_skid.sv | 90 +++++++++
 rtl/word_pipe_latch.sv | 62 ++++++
 3 files changed

// File: rtl/word_pipe_latch_pkg.sv
// Shared definitions for the elastic word pipe: per-stage occupancy states
// and the width of the chain-wide occupancy count.
package word_pipe_latch_pkg;

   // Encoding doubles as the stage occupancy (0, 1 or 2 words).
   typedef enum logic [1:0] {
      STG_EMPTY = 2'd0,
      STG_ONE   = 2'd1,
      STG_FULL  = 2'd2
   } stg_state_e;

   function automatic int occ_width(input int depth);
      return $clog2(2 * depth + 1);
   endfunction

endpackage

// File: rtl/word_pipe_latch_skid.sv
// One 2-entry skid stage: main register drives the output, skid register
// absorbs the word that arrives while downstream stalls.
module word_skid_stage
   import word_pipe_latch_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_word,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       occ
);

   stg_state_e       r_state;
   stg_state_e       w_state_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             w_ifire;
   logic             w_ofire;
   logic             w_main_from_in;
   logic             w_main_from_skid;
   logic             w_skid_from_in;

   // Ready and valid depend only on registered state (plus reset), so no
   // combinational path runs through the chain.
   assign in_ready  = (r_state != STG_FULL) && !reset;
   assign out_valid = (r_state != STG_EMPTY);
   assign out_word  = r_main;
   assign occ       = r_state;

   assign w_ifire = in_valid && in_ready;
   assign w_ofire = out_valid && out_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_main_from_in   = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
      case (r_state)
         STG_EMPTY: begin
            if (w_ifire) begin
               w_state_nxt    = STG_ONE;
               w_main_from_in = 1'b1;
            end
         end
         STG_ONE: begin
            if (w_ifire && w_ofire) begin
               w_main_from_in = 1'b1;
            end else if (w_ifire) begin
               w_state_nxt    = STG_FULL;
               w_skid_from_in = 1'b1;
            end else if (w_ofire) begin
               w_state_nxt = STG_EMPTY;
            end
         end
         STG_FULL: begin
            if (w_ofire) begin
               w_state_nxt      = STG_ONE;
               w_main_from_skid = 1'b1;
            end
         end
         default: w_state_nxt = STG_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flush) r_state <= STG_EMPTY;
      else                r_state <= w_state_nxt;
   end

   // Flush only empties the stage; the data registers keep their contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_main <= RESET_VALUE;
         r_skid <= RESET_VALUE;
      end else if (!flush) begin
         if (w_main_from_in)        r_main <= in_word;
         else if (w_main_from_skid) r_main <= r_skid;
         if (w_skid_from_in)        r_skid <= in_word;
      end
   end

endmodule

// File: rtl/word_pipe_latch.sv
// Elastic word latch: DEPTH chained skid stages with valid/ready flow
// control, synchronous flush and a total-occupancy count.
module word_pipe_latch
   import word_pipe_latch_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               DEPTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            flush,
   input  logic [WIDTH-1:0]                in_word,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [WIDTH-1:0]                out_word,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [occ_width(DEPTH)-1:0]     count
);

   localparam int CW = occ_width(DEPTH);

   logic [DEPTH:0][WIDTH-1:0] w_word;
   logic [DEPTH:0]            w_valid;
   logic [DEPTH:0]            w_ready;
   logic [DEPTH-1:0][1:0]     w_occ;
   logic [CW-1:0]             w_sum;

   assign w_word[0]      = in_word;
   assign w_valid[0]     = in_valid;
   assign in_ready       = w_ready[0];
   assign out_word       = w_word[DEPTH];
   assign out_valid      = w_valid[DEPTH];
   assign w_ready[DEPTH] = out_ready;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stg
      word_skid_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stg (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .in_word   (w_word[k]),
         .in_valid  (w_valid[k]),
         .in_ready  (w_ready[k]),
         .out_word  (w_word[k+1]),
         .out_valid (w_valid[k+1]),
         .out_ready (w_ready[k+1]),
         .occ       (w_occ[k])
      );
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < DEPTH; k++) w_sum = w_sum + CW'(w_occ[k]);
   end

   assign count = w_sum;

endmodule
